// File: rtl/cp0_interrupt_unit.sv
// ----------------------------------------------------------------------------
// cp0_interrupt_unit
//   Coprocessor-0 interrupt block for the single-cycle CPU. Holds Status,
//   Cause and EPC, decides when the timer interrupt is taken and provides
//   the eret return address.
//
// Ports
//   clock          system clock, rising-edge state updates
//   reset          synchronous active-low reset
//   regnum   [4:0] CP0 register index (12 Status, 13 Cause, 14 EPC)
//   wr_data [31:0] mtc0 write data
//   MTC0           write wr_data to regnum this cycle
//   ERET           return from exception this cycle
//   next_pc [31:0] PC saved into EPC when an interrupt is taken
//   TimerInterrupt level request from the timer
//   rd_data [31:0] mfc0 read data (combinational, no write bypass)
//   EPC     [31:0] current EPC
//   TakenInterrupt interrupt accepted this cycle (combinational)
// ----------------------------------------------------------------------------
module cp0_interrupt_unit #(
  parameter int          TIMER_IP_BIT = 15,
  parameter logic [31:0] EPC_RESET    = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  regnum,
  input  logic [31:0] wr_data,
  input  logic        MTC0,
  input  logic        ERET,
  input  logic [31:0] next_pc,
  input  logic        TimerInterrupt,
  output logic [31:0] rd_data,
  output logic [31:0] EPC,
  output logic        TakenInterrupt
);

  localparam logic [4:0]  REG_STATUS  = 5'd12;
  localparam logic [4:0]  REG_CAUSE   = 5'd13;
  localparam logic [4:0]  REG_EPC     = 5'd14;
  // Implemented Status bits: IM[15:8], EXL[1], IE[0].
  localparam logic [31:0] STATUS_MASK = 32'h0000_FF03;

  logic [31:0] status_q, status_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] cause;

  // Cause has no storage: the IP bit is the live timer level.
  always_comb begin
    cause               = 32'h0;
    cause[TIMER_IP_BIT] = TimerInterrupt;
  end

  assign TakenInterrupt = cause[TIMER_IP_BIT] & status_q[TIMER_IP_BIT] &
                          status_q[0] & ~status_q[1];
  assign EPC = epc_q;

  always_comb begin
    rd_data = 32'h0;
    case (regnum)
      REG_STATUS: rd_data = status_q;
      REG_CAUSE:  rd_data = cause;
      REG_EPC:    rd_data = epc_q;
      default:    rd_data = 32'h0;
    endcase
  end

  // Priority: interrupt entry > eret > plain mtc0. An mtc0 to Status still
  // lands its IE/IM bits under entry or eret; only EXL is overridden.
  always_comb begin
    status_d = status_q;
    epc_d    = epc_q;
    if (MTC0 && regnum == REG_STATUS) status_d = wr_data & STATUS_MASK;
    if (MTC0 && regnum == REG_EPC && !TakenInterrupt) epc_d = wr_data;
    if (TakenInterrupt) begin
      status_d[1] = 1'b1;
      epc_d       = next_pc;
    end else if (ERET) begin
      status_d[1] = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      status_q <= 32'h0;
      epc_q    <= EPC_RESET;
    end else begin
      status_q <= status_d;
      epc_q    <= epc_d;
    end
  end

endmodule

// File: tb/tb_cp0_interrupt_unit.sv
// ----------------------------------------------------------------------------
// tb_cp0_interrupt_unit
//   Directed-vector bench for cp0_interrupt_unit. Inputs change 1ns after the
//   rising edge; outputs are sampled 1ns later, well before the next edge.
// ----------------------------------------------------------------------------
module tb_cp0_interrupt_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  regnum;
  logic [31:0] wr_data;
  logic        MTC0;
  logic        ERET;
  logic [31:0] next_pc;
  logic        TimerInterrupt;
  logic [31:0] rd_data;
  logic [31:0] EPC;
  logic        TakenInterrupt;

  int n_chk  = 0;
  int n_fail = 0;

  cp0_interrupt_unit #(
    .TIMER_IP_BIT(15),
    .EPC_RESET   (32'h0000_0000)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .regnum        (regnum),
    .wr_data       (wr_data),
    .MTC0          (MTC0),
    .ERET          (ERET),
    .next_pc       (next_pc),
    .TimerInterrupt(TimerInterrupt),
    .rd_data       (rd_data),
    .EPC           (EPC),
    .TakenInterrupt(TakenInterrupt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic rd(input logic [4:0] r, input logic [31:0] exp, input string tag);
    regnum = r;
    #1;
    chk(tag, rd_data, exp);
  endtask

  task automatic taken(input logic exp, input string tag);
    #1;
    chk(tag, {31'h0, TakenInterrupt}, {31'h0, exp});
  endtask

  task automatic mtc0(input logic [4:0] r, input logic [31:0] d);
    regnum  = r;
    wr_data = d;
    MTC0    = 1'b1;
    step();
    MTC0    = 1'b0;
  endtask

  initial begin
    reset = 1'b0; regnum = 5'd0; wr_data = 32'h0; MTC0 = 1'b0; ERET = 1'b0;
    next_pc = 32'h0; TimerInterrupt = 1'b0;
    #1;
    step(); step();
    reset = 1'b1;
    #1;

    // Reset state
    rd(5'd12, 32'h0, "rst_status");
    rd(5'd13, 32'h0, "rst_cause");
    rd(5'd14, 32'h0, "rst_epc");
    chk("rst_epc_out", EPC, 32'h0);
    TimerInterrupt = 1'b1;
    taken(1'b0, "rst_taken_timer_hi");

    // Write all-ones to Status: masked, and EXL=1 holds off the interrupt.
    regnum = 5'd12; wr_data = 32'hFFFF_FFFF; MTC0 = 1'b1;
    #1;
    chk("no_bypass", rd_data, 32'h0);
    step();
    MTC0 = 1'b0;
    rd(5'd12, 32'h0000_FF03, "status_mask");
    rd(5'd13, 32'h0000_8000, "cause_ip7");
    rd(5'd7,  32'h0,         "rd_other_reg");
    taken(1'b0, "exl_masks");
    ERET = 1'b1;
    taken(1'b0, "eret_cycle_masked");
    step();
    ERET = 1'b0;
    taken(1'b1, "refire_after_eret");
    rd(5'd12, 32'h0000_FF01, "status_after_eret");
    TimerInterrupt = 1'b0;
    taken(1'b0, "timer_dropped");

    // Basic interrupt entry
    mtc0(5'd12, 32'h0000_8001);
    next_pc = 32'h0040_0020; TimerInterrupt = 1'b1;
    taken(1'b1, "take_same_cycle");
    step();
    chk("epc_saved", EPC, 32'h0040_0020);
    rd(5'd12, 32'h0000_8003, "exl_set");
    taken(1'b0, "in_handler");

    // Leave handler with timer low, then interrupt + mtc0 EPC together.
    TimerInterrupt = 1'b0; ERET = 1'b1;
    step();
    ERET = 1'b0;
    rd(5'd12, 32'h0000_8001, "eret_clears_exl");
    TimerInterrupt = 1'b1; next_pc = 32'h0040_0040;
    regnum = 5'd14; wr_data = 32'hDEAD_BEEF; MTC0 = 1'b1;
    taken(1'b1, "take_with_mtc0_epc");
    step();
    MTC0 = 1'b0;
    chk("epc_write_dropped", EPC, 32'h0040_0040);

    // mtc0 EPC with IE=0 goes through.
    mtc0(5'd12, 32'h0000_8000);
    regnum = 5'd14; wr_data = 32'hDEAD_BEEF; MTC0 = 1'b1;
    taken(1'b0, "ie0_no_take");
    step();
    MTC0 = 1'b0;
    chk("epc_mtc0", EPC, 32'hDEAD_BEEF);

    // mtc0 Status during entry: IE/IM written, EXL forced.
    TimerInterrupt = 1'b0;
    mtc0(5'd12, 32'h0000_8001);
    TimerInterrupt = 1'b1; next_pc = 32'h0040_0060;
    regnum = 5'd12; wr_data = 32'h0000_0101; MTC0 = 1'b1;
    taken(1'b1, "take_with_mtc0_status");
    step();
    MTC0 = 1'b0;
    rd(5'd12, 32'h0000_0103, "status_exl_forced");
    chk("epc_entry2", EPC, 32'h0040_0060);

    // In handler with timer still high: eret re-fires.
    mtc0(5'd12, 32'h0000_8003);
    taken(1'b0, "handler_masked");
    ERET = 1'b1;
    step();
    ERET = 1'b0;
    taken(1'b1, "refire_timer_high");
    next_pc = 32'h0040_0080;
    step();
    chk("epc_refire", EPC, 32'h0040_0080);
    TimerInterrupt = 1'b0; ERET = 1'b1;
    step();
    ERET = 1'b0;
    taken(1'b0, "no_refire_timer_low");
    rd(5'd12, 32'h0000_8001, "status_after_eret2");

    // ERET and interrupt together: interrupt wins.
    TimerInterrupt = 1'b1; ERET = 1'b1; next_pc = 32'h0040_00C0;
    taken(1'b1, "take_with_eret");
    step();
    ERET = 1'b0;
    chk("epc_take_wins", EPC, 32'h0040_00C0);
    rd(5'd12, 32'h0000_8003, "exl_take_wins");

    // ERET plus mtc0 Status: EXL cleared regardless of wr_data.
    TimerInterrupt = 1'b0;
    regnum = 5'd12; wr_data = 32'h0000_0002; MTC0 = 1'b1; ERET = 1'b1;
    step();
    MTC0 = 1'b0; ERET = 1'b0;
    rd(5'd12, 32'h0, "eret_mtc0_status");

    // Reset overrides a taken interrupt.
    mtc0(5'd12, 32'h0000_8001);
    TimerInterrupt = 1'b1; next_pc = 32'h1234_5678; reset = 1'b0;
    taken(1'b1, "take_during_reset");
    step();
    reset = 1'b1; TimerInterrupt = 1'b0;
    chk("reset_epc", EPC, 32'h0);
    rd(5'd12, 32'h0, "reset_status");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
